// File: rtl/montgomery_pkg.sv
// Shared types and sizing helpers for the word-serial Montgomery reducer.
package montgomery_pkg;

   // Controller states of the reducer.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      CALC_M = 3'd2,
      MAC    = 3'd3,
      CARRY  = 3'd4,
      SUB    = 3'd5,
      OUT    = 3'd6
   } state_t;

   // Default configuration (Paillier datapath: 32-bit words, 4096-bit modulus).
   localparam int DEFAULT_REGISTER_SIZE  = 32;
   localparam int DEFAULT_NUM_BLOCKS_OUT = 128;
   localparam int T_BLOCKS               = 2 * DEFAULT_NUM_BLOCKS_OUT;
   localparam int SCRATCH_BLOCKS         = 2 * DEFAULT_NUM_BLOCKS_OUT + 1;

   // Width of a counter that must hold values 0..n-1 (never narrower than 1 bit).
   function automatic int cnt_width(input int n);
      if (n > 1) begin
         return $clog2(n);
      end else begin
         return 1;
      end
   endfunction

   // Number of T words for a modulus of s words.
   function automatic int t_blocks(input int s);
      return 2 * s;
   endfunction

   // Scratch words: T plus one extra top word.
   function automatic int scratch_blocks(input int s);
      return 2 * s + 1;
   endfunction

endpackage

// File: rtl/word_mac.sv
// Combinational word multiply-accumulate: {o_hi, o_lo} = i_a + i_b*i_c + i_d.
// The worst case (2^w-1) + (2^w-1)^2 + (2^w-1) = 2^(2w)-1 always fits in 2w bits.
module word_mac
   import montgomery_pkg::*;
#(
   parameter int WIDTH = DEFAULT_REGISTER_SIZE
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [WIDTH-1:0] i_c,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);

   localparam int DW = 2 * WIDTH;

   logic [DW-1:0] w_prod;
   logic [DW-1:0] w_sum;

   // Full-width product plus both addends.
   always_comb begin
      w_prod = DW'(i_b) * DW'(i_c);
      w_sum  = w_prod + DW'(i_a) + DW'(i_d);
   end

   assign o_hi = w_sum[DW-1:WIDTH];
   assign o_lo = w_sum[WIDTH-1:0];

endmodule

// File: rtl/montgomery_reduce_wordserial.sv
// Word-serial Montgomery reduction: result = T * R^-1 mod N, R = 2^(w*S).
// One w x w multiplier is time-shared between the m computation and the MAC pass;
// a word-serial subtractor performs the final conditional subtraction.
module montgomery_reduce_wordserial
   import montgomery_pkg::*;
#(
   parameter int REGISTER_SIZE  = DEFAULT_REGISTER_SIZE,
   parameter int NUM_BLOCKS_OUT = DEFAULT_NUM_BLOCKS_OUT
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     n_valid_in,
   input  logic [REGISTER_SIZE-1:0] n_block_in,
   input  logic [REGISTER_SIZE-1:0] n_prime_in,
   output logic                     n_loaded_out,
   input  logic                     valid_in,
   input  logic [REGISTER_SIZE-1:0] T_block_in,
   output logic                     ready_out,
   output logic                     valid_out,
   output logic [REGISTER_SIZE-1:0] data_block_out,
   output logic                     last_out,
   input  logic                     ready_in,
   output logic                     busy_out
);

   localparam int W     = REGISTER_SIZE;
   localparam int S     = NUM_BLOCKS_OUT;
   localparam int TW    = t_blocks(S);
   localparam int SW    = scratch_blocks(S);
   localparam int S_CW  = cnt_width(S);
   localparam int T_CW  = cnt_width(TW);
   localparam int IDX_W = cnt_width(SW);

   localparam logic [S_CW-1:0]  S_LAST  = S_CW'(S - 1);
   localparam logic [S_CW-1:0]  S_ONE   = S_CW'(1'b1);
   localparam logic [T_CW-1:0]  T_LAST  = T_CW'(TW - 1);
   localparam logic [T_CW-1:0]  T_ONE   = T_CW'(1'b1);
   localparam logic [IDX_W-1:0] IDX_S   = IDX_W'(S);
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(TW);

   state_t r_state;
   state_t w_next_state;

   logic [W-1:0]     r_n       [S];
   logic [W-1:0]     r_scratch [SW];
   logic [W-1:0]     r_diff    [S];
   logic [W-1:0]     r_n_prime;
   logic [W-1:0]     r_m;
   logic [W-1:0]     r_c;
   logic             r_c_top;
   logic             r_borrow;
   logic [S_CW-1:0]  r_n_cnt;
   logic [S_CW-1:0]  r_i;
   logic [S_CW-1:0]  r_j;
   logic [S_CW-1:0]  r_out_cnt;
   logic [T_CW-1:0]  r_load_cnt;
   logic             r_n_loaded;
   logic             r_busy;
   logic             r_valid_out;
   logic             r_last_out;
   logic [W-1:0]     r_data_out;

   logic             w_t_accept;
   logic             w_n_accept;
   logic [IDX_W-1:0] w_mac_idx;
   logic [IDX_W-1:0] w_top_idx;
   logic [IDX_W-1:0] w_sub_idx;
   logic [IDX_W-1:0] w_out_idx;
   logic [W-1:0]     w_mac_a;
   logic [W-1:0]     w_mac_b;
   logic [W-1:0]     w_mac_c;
   logic [W-1:0]     w_mac_d;
   logic [W-1:0]     w_mac_hi;
   logic [W-1:0]     w_mac_lo;
   logic [W:0]       w_carry_sum;
   logic [W:0]       w_sub_res;
   logic             w_sel_diff;
   logic [W-1:0]     w_out_word;
   logic             w_out_load;

   assign n_loaded_out   = r_n_loaded;
   assign busy_out       = r_busy;
   assign valid_out      = r_valid_out;
   assign last_out       = r_last_out;
   assign data_block_out = r_data_out;

   // T words are taken in IDLE (once N is held and no N word competes) and in LOAD.
   always_comb begin
      ready_out = 1'b0;
      case (r_state)
         IDLE:    ready_out = r_n_loaded && !n_valid_in;
         LOAD:    ready_out = 1'b1;
         default: ready_out = 1'b0;
      endcase
   end

   assign w_t_accept = valid_in && ready_out;
   assign w_n_accept = n_valid_in && (r_state == IDLE);

   assign w_mac_idx = IDX_W'(r_i) + IDX_W'(r_j);
   assign w_top_idx = IDX_W'(r_i) + IDX_S;
   assign w_sub_idx = IDX_W'(r_j) + IDX_S;
   assign w_out_idx = IDX_W'(r_out_cnt) + IDX_S;

   // c_top carries into the word above i+S, which is exactly the next row's CARRY word.
   assign w_carry_sum = {1'b0, r_scratch[w_top_idx]} + {1'b0, r_c} + {{W{1'b0}}, r_c_top};
   assign w_sub_res   = {1'b0, r_scratch[w_sub_idx]} - {1'b0, r_n[r_j]} - {{W{1'b0}}, r_borrow};

   // Take the difference when t overflowed into c_top or t >= N.
   assign w_sel_diff = r_c_top || !r_borrow;
   assign w_out_word = w_sel_diff ? r_diff[r_out_cnt] : r_scratch[w_out_idx];
   assign w_out_load = (r_state == OUT) && (!r_valid_out || (ready_in && !r_last_out));

   // Multiplier operand steering: m = scratch[i]*n' in CALC_M, row MAC in MAC.
   always_comb begin
      w_mac_a = '0;
      w_mac_b = '0;
      w_mac_c = '0;
      w_mac_d = '0;
      case (r_state)
         CALC_M: begin
            w_mac_b = r_scratch[IDX_W'(r_i)];
            w_mac_c = r_n_prime;
         end
         MAC: begin
            w_mac_a = r_scratch[w_mac_idx];
            w_mac_b = r_m;
            w_mac_c = r_n[r_j];
            w_mac_d = r_c;
         end
         default: begin
            w_mac_a = '0;
         end
      endcase
   end

   word_mac #(
      .WIDTH (W)
   ) u_word_mac (
      .i_a  (w_mac_a),
      .i_b  (w_mac_b),
      .i_c  (w_mac_c),
      .i_d  (w_mac_d),
      .o_hi (w_mac_hi),
      .o_lo (w_mac_lo)
   );

   // Next-state logic.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (w_t_accept) w_next_state = LOAD;
            else            w_next_state = IDLE;
         end
         LOAD: begin
            if (w_t_accept && (r_load_cnt == T_LAST)) w_next_state = CALC_M;
            else                                      w_next_state = LOAD;
         end
         CALC_M: w_next_state = MAC;
         MAC: begin
            if (r_j == S_LAST) w_next_state = CARRY;
            else               w_next_state = MAC;
         end
         CARRY: begin
            if (r_i == S_LAST) w_next_state = SUB;
            else               w_next_state = CALC_M;
         end
         SUB: begin
            if (r_j == S_LAST) w_next_state = OUT;
            else               w_next_state = SUB;
         end
         OUT: begin
            if (r_valid_out && ready_in && r_last_out) w_next_state = IDLE;
            else                                       w_next_state = OUT;
         end
         default: w_next_state = IDLE;
      endcase
   end

   // State register and busy flag.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state <= IDLE;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_busy  <= (w_next_state != IDLE);
      end
   end

   // N word counter, n' capture and loaded flag.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_n_cnt    <= '0;
         r_n_loaded <= 1'b0;
         r_n_prime  <= '0;
      end else if (w_n_accept) begin
         if (r_n_cnt == '0) r_n_prime <= n_prime_in;
         if (r_n_cnt == S_LAST) begin
            r_n_cnt    <= '0;
            r_n_loaded <= 1'b1;
         end else begin
            r_n_cnt    <= r_n_cnt + S_ONE;
            r_n_loaded <= 1'b0;
         end
      end
   end

   // N word storage.
   always_ff @(posedge clk_in) begin
      if (w_n_accept) r_n[r_n_cnt] <= n_block_in;
   end

   // Scratch (T / running sum) and difference storage.
   always_ff @(posedge clk_in) begin
      case (r_state)
         IDLE: begin
            if (w_t_accept) begin
               r_scratch[{IDX_W{1'b0}}] <= T_block_in;
               r_scratch[IDX_TOP]       <= '0;
            end
         end
         LOAD: begin
            if (w_t_accept) r_scratch[IDX_W'(r_load_cnt)] <= T_block_in;
         end
         MAC:   r_scratch[w_mac_idx] <= w_mac_lo;
         CARRY: r_scratch[w_top_idx] <= w_carry_sum[W-1:0];
         SUB:   r_diff[r_j]          <= w_sub_res[W-1:0];
         default: begin
         end
      endcase
   end

   // Sequencing counters, m, carries and borrow.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_load_cnt <= '0;
         r_i        <= '0;
         r_j        <= '0;
         r_m        <= '0;
         r_c        <= '0;
         r_c_top    <= 1'b0;
         r_borrow   <= 1'b0;
         r_out_cnt  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_t_accept) begin
                  r_load_cnt <= T_ONE;
                  r_c_top    <= 1'b0;
               end
            end
            LOAD: begin
               if (w_t_accept) begin
                  if (r_load_cnt == T_LAST) begin
                     r_load_cnt <= '0;
                     r_i        <= '0;
                  end else begin
                     r_load_cnt <= r_load_cnt + T_ONE;
                  end
               end
            end
            CALC_M: begin
               r_m <= w_mac_lo;
               r_c <= '0;
               r_j <= '0;
            end
            MAC: begin
               r_c <= w_mac_hi;
               if (r_j == S_LAST) r_j <= '0;
               else               r_j <= r_j + S_ONE;
            end
            CARRY: begin
               r_c_top <= w_carry_sum[W];
               if (r_i == S_LAST) begin
                  r_i      <= '0;
                  r_j      <= '0;
                  r_borrow <= 1'b0;
               end else begin
                  r_i <= r_i + S_ONE;
               end
            end
            SUB: begin
               r_borrow <= w_sub_res[W];
               if (r_j == S_LAST) begin
                  r_j       <= '0;
                  r_out_cnt <= '0;
               end else begin
                  r_j <= r_j + S_ONE;
               end
            end
            OUT: begin
               if (w_out_load) r_out_cnt <= r_out_cnt + S_ONE;
            end
            default: begin
            end
         endcase
      end
   end

   // Result word register: loads a word when empty or when the current one is taken.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_valid_out <= 1'b0;
         r_last_out  <= 1'b0;
         r_data_out  <= '0;
      end else if (r_state == OUT) begin
         if (w_out_load) begin
            r_valid_out <= 1'b1;
            r_data_out  <= w_out_word;
            r_last_out  <= (r_out_cnt == S_LAST);
         end else if (r_valid_out && ready_in && r_last_out) begin
            r_valid_out <= 1'b0;
            r_last_out  <= 1'b0;
         end
      end else begin
         r_valid_out <= 1'b0;
         r_last_out  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_montgomery_reduce_wordserial.sv
// Randomized self-checking bench for montgomery_reduce_wordserial (w=8, S=2).
// Expected results come from plain modular arithmetic: T * R^-1 mod N.
module tb_montgomery_reduce_wordserial;

   localparam int W = 8;
   localparam int S = 2;
   localparam longint unsigned R = 64'h1 << (W * S);
   localparam int LATENCY = S * (S + 2) + S + 1;

   logic         clk_in = 1'b0;
   logic         rst_in;
   logic         n_valid_in;
   logic [W-1:0] n_block_in;
   logic [W-1:0] n_prime_in;
   logic         n_loaded_out;
   logic         valid_in;
   logic [W-1:0] T_block_in;
   logic         ready_out;
   logic         valid_out;
   logic [W-1:0] data_block_out;
   logic         last_out;
   logic         ready_in;
   logic         busy_out;

   int n_checks = 0;
   int n_errors = 0;

   longint unsigned cur_n;
   longint unsigned cur_rinv;
   logic [W-1:0]    cur_np;

   montgomery_reduce_wordserial #(
      .REGISTER_SIZE  (W),
      .NUM_BLOCKS_OUT (S)
   ) dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .n_valid_in     (n_valid_in),
      .n_block_in     (n_block_in),
      .n_prime_in     (n_prime_in),
      .n_loaded_out   (n_loaded_out),
      .valid_in       (valid_in),
      .T_block_in     (T_block_in),
      .ready_out      (ready_out),
      .valid_out      (valid_out),
      .data_block_out (data_block_out),
      .last_out       (last_out),
      .ready_in       (ready_in),
      .busy_out       (busy_out)
   );

   always #5 clk_in = ~clk_in;

   // Single comparison point: counts every check and reports mismatches.
   task automatic check_eq(input string tag, input longint unsigned obs, input longint unsigned exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // -N^-1 mod 2^W by search.
   function automatic longint unsigned ref_nprime(input longint unsigned n);
      for (int x = 0; x < (1 << W); x++) begin
         if (((n * longint'(x)) % (64'h1 << W)) == ((64'h1 << W) - 1)) return longint'(x);
      end
      return 0;
   endfunction

   // R^-1 mod N by search.
   function automatic longint unsigned ref_rinv(input longint unsigned n);
      longint unsigned rmod;
      if (n <= 1) return 0;
      rmod = R % n;
      for (longint unsigned x = 1; x < n; x++) begin
         if (((rmod * x) % n) == 1) return x;
      end
      return 0;
   endfunction

   function automatic longint unsigned ref_redc(input longint unsigned t);
      if (cur_n <= 1) return 0;
      return ((t % cur_n) * cur_rinv) % cur_n;
   endfunction

   // Loads N word-serially; n' only on the first word (later words carry junk there).
   task automatic load_n(input longint unsigned n);
      cur_n    = n;
      cur_np   = W'(ref_nprime(n));
      cur_rinv = ref_rinv(n);
      for (int k = 0; k < S; k++) begin
         n_valid_in = 1'b1;
         n_block_in = W'(n >> (W * k));
         n_prime_in = (k == 0) ? cur_np : W'($urandom);
         #1;
         if (k == 0) check_eq("ready_during_nload", ready_out, 0);
         @(posedge clk_in);
         @(negedge clk_in);
         if (k < S - 1) check_eq("n_loaded_partial", n_loaded_out, 0);
      end
      n_valid_in = 1'b0;
      n_block_in = '0;
      n_prime_in = '0;
      #1;
      check_eq("n_loaded_done", n_loaded_out, 1);
   endtask

   // Sends 2S T words, optionally with idle gaps; returns at the negedge after the last accept.
   task automatic send_t(input longint unsigned t, input bit gaps);
      int wait_cnt;
      for (int k = 0; k < 2 * S; k++) begin
         if (gaps && (k > 0) && ($urandom_range(0, 1) == 1)) begin
            valid_in = 1'b0;
            @(posedge clk_in);
            @(negedge clk_in);
         end
         valid_in   = 1'b1;
         T_block_in = W'(t >> (W * k));
         #1;
         wait_cnt = 0;
         while (!ready_out && (wait_cnt < 50)) begin
            @(negedge clk_in);
            #1;
            wait_cnt++;
         end
         if (!ready_out) check_eq("t_ready", ready_out, 1);
         @(posedge clk_in);
         @(negedge clk_in);
      end
      valid_in   = 1'b0;
      T_block_in = '0;
   endtask

   // Collects S result words, stalling ready_in for 'stall' cycles on each word.
   task automatic get_result(input int stall, output longint unsigned res);
      int wait_cnt;
      logic [W-1:0] held;
      res = 0;
      for (int j = 0; j < S; j++) begin
         wait_cnt = 0;
         while (!valid_out && (wait_cnt < 50)) begin
            @(negedge clk_in);
            wait_cnt++;
         end
         if (!valid_out) check_eq("out_valid", valid_out, 1);
         held = data_block_out;
         check_eq("last_flag", last_out, (j == S - 1));
         res |= longint'(held) << (W * j);
         for (int s = 0; s < stall; s++) begin
            @(negedge clk_in);
            check_eq("stall_valid", valid_out, 1);
            check_eq("stall_data", data_block_out, held);
         end
         ready_in = 1'b1;
         @(posedge clk_in);
         @(negedge clk_in);
         ready_in = 1'b0;
      end
      check_eq("valid_after_last", valid_out, 0);
      check_eq("busy_after_last", busy_out, 0);
   endtask

   // One full reduction: send T, check latency and busy blocking, collect and compare.
   task automatic run_case(input string tag, input longint unsigned t, input bit gaps, input int stall);
      int lat;
      longint unsigned res;
      longint unsigned exp;
      exp = ref_redc(t);
      send_t(t, gaps);
      lat = 0;
      while (!valid_out && (lat < 200)) begin
         if (lat == 2) begin
            valid_in   = 1'b1;
            T_block_in = W'($urandom);
            #1;
            check_eq("ready_while_busy", ready_out, 0);
            check_eq("busy_while_busy", busy_out, 1);
            valid_in   = 1'b0;
         end
         @(negedge clk_in);
         lat++;
      end
      check_eq({tag, "_latency"}, longint'(lat), longint'(LATENCY));
      get_result(stall, res);
      check_eq(tag, res, exp);
   endtask

   initial begin
      longint unsigned t;
      rst_in     = 1'b1;
      n_valid_in = 1'b0;
      n_block_in = '0;
      n_prime_in = '0;
      valid_in   = 1'b0;
      T_block_in = '0;
      ready_in   = 1'b0;
      repeat (3) @(posedge clk_in);
      @(negedge clk_in);
      check_eq("rst_valid_out", valid_out, 0);
      check_eq("rst_last_out", last_out, 0);
      check_eq("rst_data_out", data_block_out, 0);
      check_eq("rst_ready_out", ready_out, 0);
      check_eq("rst_busy_out", busy_out, 0);
      check_eq("rst_n_loaded", n_loaded_out, 0);
      rst_in = 1'b0;
      @(negedge clk_in);

      // Directed vectors with N = 0xE3C5.
      load_n(64'hE3C5);
      run_case("t_zero",     64'h0000_0000, 1'b0, 0);
      run_case("t_eq_n",     64'h0000_E3C5, 1'b0, 0);
      run_case("t_eq_r",     64'h0001_0000, 1'b0, 0);
      run_case("t_sub_path", 64'hE3CA_0000, 1'b0, 0);
      run_case("t_stall",    64'hE3C4_0000, 1'b0, 3);

      // Random T against the same N.
      for (int k = 0; k < 16; k++) begin
         t = {$urandom, $urandom} % (cur_n * R);
         run_case("rand_t", t, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
      end

      // Reset during MAC, then recover.
      send_t(64'h0001_0000, 1'b0);
      @(negedge clk_in);
      check_eq("busy_before_rst", busy_out, 1);
      rst_in = 1'b1;
      @(posedge clk_in);
      @(negedge clk_in);
      check_eq("midrst_valid_out", valid_out, 0);
      check_eq("midrst_busy_out", busy_out, 0);
      check_eq("midrst_n_loaded", n_loaded_out, 0);
      check_eq("midrst_ready_out", ready_out, 0);
      rst_in = 1'b0;
      @(negedge clk_in);
      load_n(64'hE3C5);
      run_case("after_reset", 64'h0001_0000, 1'b0, 0);

      // Random odd moduli.
      for (int m = 0; m < 3; m++) begin
         load_n(longint'($urandom_range(3, 65535) | 1));
         for (int k = 0; k < 6; k++) begin
            t = {$urandom, $urandom} % (cur_n * R);
            run_case("rand_n", t, 1'($urandom_range(0, 1)), $urandom_range(0, 1));
         end
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   // Time limit so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog: observed=time limit reached expected=normal finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/montgomery_reduce_wordserial.md
Name: montgomery_reduce_wordserial

Overview:
- Word-serial Montgomery reduction (REDC): computes T·R⁻¹ mod N, with R = 2^(REGISTER_SIZE·NUM_BLOCKS_OUT).
- Uses one REGISTER_SIZE×REGISTER_SIZE multiply per step instead of full-width multipliers. Result is deterministic in cycle count.
- Successor to the block-streamed reducer: parametric width and depth, internal N storage, ready/valid on input and output, built-in final conditional subtraction.
- Sits between the modular multiplier and the exponentiation controller of the Paillier datapath.

Parameters:
- REGISTER_SIZE, 32, word width w in bits.
- NUM_BLOCKS_OUT, 128, S = number of words in N and in the result. T has 2S words; R = 2^(w·S).

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  reset.
- n_valid_in  input  1  N word strobe, least significant word first; S words per load.
- n_block_in  input  w  N word.
- n_prime_in  input  w  -N⁻¹ mod 2^w. Sampled with the first N word.
- n_loaded_out  output  1  high once all S words of N are held.
- valid_in  input  1  T word valid.
- T_block_in  input  w  T word, least significant word first, 2S words.
- ready_out  output  1  T word accepted when valid_in && ready_out.
- valid_out  output  1  result word valid.
- data_block_out  output  w  result word, least significant word first.
- last_out  output  1  marks word S-1 of the result.
- ready_in  input  1  downstream accepts the result word.
- busy_out  output  1  high in any state other than IDLE.

Behaviour:
- Clocking and reset:
  - One clock, clk_in. Reset rst_in is synchronous, active-high.
  - Reset values: valid_out=0, last_out=0, data_block_out=0, ready_out=0, busy_out=0, n_loaded_out=0. All counters 0, state IDLE.
  - Reset mid-operation aborts immediately and discards N and T.
- N load:
  - Accepted only in IDLE. A word counter wraps after S words; n_loaded_out then goes to 1.
  - A new N load in IDLE clears n_loaded_out until all S words arrive.
- State IDLE:
  - ready_out = n_loaded_out && !n_valid_in.
  - The first accepted T word moves to LOAD.
- State LOAD:
  - ready_out=1. Writes 2S words into scratch words 0..2S-1; scratch word 2S and carry register c_top are cleared.
  - Gaps in valid_in are allowed. After word 2S-1, go to CALC_M with i=0.
- State CALC_M (1 cycle): m = (scratch[i]·n_prime) mod 2^w; clear carry c.
- State MAC (S cycles, j=0..S-1):
  - {c, scratch[i+j]} = scratch[i+j] + m·N[j] + c.
  - c is w bits wide; the sum fits in 2w bits.
- State CARRY (1 cycle):
  - {c_top, scratch[i+S]} = scratch[i+S] + c + c_top.
  - If i=S-1, go to SUB; otherwise increment i and go to CALC_M.
- Reduction cost is exactly S·(S+2) cycles.
- State SUB (S cycles):
  - Word-serial d[j] = scratch[S+j] - N[j] - borrow, stored in a diff array; final borrow b is held.
  - Selection: sel_diff = c_top || !b.
- State OUT:
  - Emits word j of (sel_diff ? d : scratch[S..2S-1]) with valid_out=1.
  - Word counter advances only on valid_out && ready_in; data is held stable while ready_in=0.
  - last_out=1 on word S-1. After that handshake, return to IDLE next cycle with valid_out=0.
- Total latency from the last T word accepted to the first valid_out: S·(S+2)+S+1 cycles.
- Input precondition: T < N·R, N odd, N < R. Result is always < N.
- T words offered outside LOAD or IDLE are not accepted (ready_out=0).

Decomposition:
- Package montgomery_pkg:
  - state enum: IDLE, LOAD, CALC_M, MAC, CARRY, SUB, OUT;
  - function clog2-based counter width;
  - localparams T_BLOCKS=2·NUM_BLOCKS_OUT and SCRATCH_BLOCKS=2·NUM_BLOCKS_OUT+1.
- Sub-module word_mac: combinational a + b·c + d returning {hi, lo} at 2w width. Shared by CALC_M (low half only) and MAC.

Test Plan (REGISTER_SIZE=8, NUM_BLOCKS_OUT=2, R=0x10000, N=0xE3C5, n_prime=0xF3):
- T=0x00000000 -> result words 0x00,0x00; last_out on second word; first valid_out exactly 2·4+2+1=11 cycles after the last T word.
- T=0x0000E3C5 (T=N) -> result 0x0000.
- T=0x00010000 (T=R) -> result 0x0001, no subtraction taken.
- T=0xE3CA0000 (t=N+5 before the final stage) -> subtraction path taken; result 0x0005.
- T=0xE3C40000 -> result 0xE3C4; hold ready_in=0 for 3 cycles on word 0 -> data_block_out and valid_out stay stable.
- Assert rst_in during MAC -> next cycle valid_out=0, busy_out=0, n_loaded_out=0. Reload N and send T=R -> result 0x0001.
